alu_muldiv: RTL and testbench

//  Parametrised successor ALU for the pipelined core's EX stage. Adds SRA, SLT/SLTU and

---
 rtl/alu_muldiv.sv | 184 ++++++++++++++++++
 tb/tb_alu_muldiv.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_muldiv.sv
// EX-stage ALU with single-cycle logic/arith/shift/compare ops and iterative
// shift-add multiply / restoring divide behind valid/ready handshakes.
module alu_muldiv #(
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned SHAMT_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             overflow
);

    localparam int unsigned PROD_W = 2 * WIDTH;

    localparam logic [3:0] OP_ADD   = 4'd0;
    localparam logic [3:0] OP_SUB   = 4'd1;
    localparam logic [3:0] OP_AND   = 4'd2;
    localparam logic [3:0] OP_OR    = 4'd3;
    localparam logic [3:0] OP_XOR   = 4'd4;
    localparam logic [3:0] OP_SLL   = 4'd5;
    localparam logic [3:0] OP_SRL   = 4'd6;
    localparam logic [3:0] OP_SRA   = 4'd7;
    localparam logic [3:0] OP_SLT   = 4'd8;
    localparam logic [3:0] OP_SLTU  = 4'd9;
    localparam logic [3:0] OP_MUL   = 4'd10;
    localparam logic [3:0] OP_MULHU = 4'd11;
    localparam logic [3:0] OP_DIVU  = 4'd12;
    localparam logic [3:0] OP_REMU  = 4'd13;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state, next_state;

    logic [3:0]         op_q;
    logic [WIDTH-1:0]   mcand_q;
    logic [PROD_W-1:0]  prod_q;
    logic [WIDTH-1:0]   divisor_q;
    logic [WIDTH-1:0]   quot_q;
    logic [WIDTH-1:0]   rem_q;
    logic [SHAMT_W-1:0] cnt_q;

    logic               accept;
    logic               is_multi;
    logic               last_step;

    logic [WIDTH-1:0]   b_eff;
    logic [WIDTH-1:0]   sum;
    logic [SHAMT_W-1:0] shamt;
    logic [WIDTH-1:0]   alu_res;
    logic               alu_ovf;

    logic [WIDTH:0]     mul_add;
    logic [PROD_W-1:0]  mul_next;
    logic [WIDTH:0]     rem_sh;
    logic [WIDTH:0]     diff;
    logic               div_ge;
    logic [WIDTH-1:0]   quot_next;
    logic [WIDTH-1:0]   rem_next;
    logic [WIDTH-1:0]   iter_res;

    assign accept    = in_valid && (state == IDLE) && !flush;
    assign is_multi  = op inside {OP_MUL, OP_MULHU, OP_DIVU, OP_REMU};
    assign last_step = (cnt_q == SHAMT_W'(WIDTH - 1));

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic; flush wins over every handshake
    always_comb begin
        next_state = state;
        if (flush) begin
            next_state = IDLE;
        end else begin
            case (state)
                IDLE:    if (accept) next_state = is_multi ? BUSY : DONE;
                BUSY:    if (last_step) next_state = DONE;
                DONE:    if (out_ready) next_state = IDLE;
                default: next_state = IDLE;
            endcase
        end
    end

    // Single-cycle datapath; SUB adds the two's complement of b
    always_comb begin
        b_eff   = (op == OP_SUB) ? (~b + WIDTH'(1)) : b;
        sum     = a + b_eff;
        shamt   = b[SHAMT_W-1:0];
        alu_res = '0;
        alu_ovf = 1'b0;
        case (op)
            OP_ADD, OP_SUB: begin
                alu_res = sum;
                alu_ovf = (a[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
            end
            OP_AND:  alu_res = a & b;
            OP_OR:   alu_res = a | b;
            OP_XOR:  alu_res = a ^ b;
            OP_SLL:  alu_res = a << shamt;
            OP_SRL:  alu_res = a >> shamt;
            OP_SRA:  alu_res = $unsigned($signed(a) >>> shamt);
            OP_SLT:  alu_res = WIDTH'($signed(a) < $signed(b));
            OP_SLTU: alu_res = WIDTH'(a < b);
            default: alu_res = '0;
        endcase
    end

    // One multiply step and one divide step per BUSY cycle
    always_comb begin
        mul_add   = {1'b0, prod_q[PROD_W-1:WIDTH]} + (prod_q[0] ? {1'b0, mcand_q} : '0);
        mul_next  = {mul_add, prod_q[WIDTH-1:1]};
        rem_sh    = {rem_q, quot_q[WIDTH-1]};
        div_ge    = (rem_sh >= {1'b0, divisor_q});
        diff      = rem_sh - {1'b0, divisor_q};
        quot_next = {quot_q[WIDTH-2:0], div_ge};
        rem_next  = div_ge ? diff[WIDTH-1:0] : rem_sh[WIDTH-1:0];
        case (op_q)
            OP_MUL:   iter_res = mul_next[WIDTH-1:0];
            OP_MULHU: iter_res = mul_next[PROD_W-1:WIDTH];
            OP_DIVU:  iter_res = quot_next;
            default:  iter_res = rem_next;
        endcase
    end

    // Registered outputs and iterative operand state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            result    <= '0;
            overflow  <= 1'b0;
            op_q      <= '0;
            mcand_q   <= '0;
            prod_q    <= '0;
            divisor_q <= '0;
            quot_q    <= '0;
            rem_q     <= '0;
            cnt_q     <= '0;
        end else begin
            in_ready  <= (next_state == IDLE);
            out_valid <= (next_state == DONE);
            if (accept) begin
                op_q      <= op;
                mcand_q   <= a;
                prod_q    <= {{WIDTH{1'b0}}, b};
                divisor_q <= b;
                quot_q    <= a;
                rem_q     <= '0;
                cnt_q     <= '0;
                if (!is_multi) begin
                    result   <= alu_res;
                    overflow <= alu_ovf;
                end
            end else if ((state == BUSY) && !flush) begin
                prod_q <= mul_next;
                quot_q <= quot_next;
                rem_q  <= rem_next;
                cnt_q  <= cnt_q + SHAMT_W'(1);
                if (last_step) begin
                    result   <= iter_res;
                    overflow <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_alu_muldiv.sv
// Self-checking bench for alu_muldiv: directed vectors plus a latency-level
// reference model compared against the DUT outputs every cycle.
module tb_alu_muldiv;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        overflow;

    int checks = 0;
    int errors = 0;

    alu_muldiv #(.WIDTH(32), .SHAMT_W(5)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .op(op), .a(a), .b(b),
        .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .overflow(overflow)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] res;
        logic        ovf;
    } exp_t;

    typedef struct {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] r;
        logic        v;
    } vec_t;

    vec_t vecs [18] = '{
        '{4'd0,  32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1'b1},
        '{4'd1,  32'h80000000, 32'h00000001, 32'h7FFFFFFF, 1'b1},
        '{4'd0,  32'h00000005, 32'h00000003, 32'h00000008, 1'b0},
        '{4'd2,  32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 1'b0},
        '{4'd3,  32'hF0F0F0F0, 32'h0F0F0000, 32'hFFFFF0F0, 1'b0},
        '{4'd4,  32'hFFFF0000, 32'h0F0F0F0F, 32'hF0F00F0F, 1'b0},
        '{4'd5,  32'h00000001, 32'h00000021, 32'h00000002, 1'b0},
        '{4'd6,  32'h80000000, 32'h00000004, 32'h08000000, 1'b0},
        '{4'd7,  32'h80000000, 32'h00000024, 32'hF8000000, 1'b0},
        '{4'd8,  32'hFFFFFFFF, 32'h00000001, 32'h00000001, 1'b0},
        '{4'd9,  32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b0},
        '{4'd14, 32'h12345678, 32'h9ABCDEF0, 32'h00000000, 1'b0},
        '{4'd10, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 1'b0},
        '{4'd11, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 1'b0},
        '{4'd12, 32'd100,      32'd7,        32'd14,       1'b0},
        '{4'd13, 32'd100,      32'd7,        32'd2,        1'b0},
        '{4'd12, 32'd5,        32'd0,        32'hFFFFFFFF, 1'b0},
        '{4'd13, 32'd5,        32'd0,        32'd5,        1'b0}
    };

    // Reference arithmetic straight from the op table
    function automatic exp_t model(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y);
        exp_t        e;
        logic [31:0] addend;
        logic [63:0] p;
        e      = '0;
        addend = (o == 4'd1) ? (32'd0 - y) : y;
        p      = 64'(x) * 64'(y);
        case (o)
            4'd0, 4'd1: begin
                e.res = x + addend;
                e.ovf = (x[31] == addend[31]) && (e.res[31] != x[31]);
            end
            4'd2:  e.res = x & y;
            4'd3:  e.res = x | y;
            4'd4:  e.res = x ^ y;
            4'd5:  e.res = x << y[4:0];
            4'd6:  e.res = x >> y[4:0];
            4'd7:  e.res = $unsigned($signed(x) >>> y[4:0]);
            4'd8:  e.res = ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
            4'd9:  e.res = (x < y) ? 32'd1 : 32'd0;
            4'd10: e.res = p[31:0];
            4'd11: e.res = p[63:32];
            4'd12: e.res = (y == 0) ? 32'hFFFFFFFF : x / y;
            4'd13: e.res = (y == 0) ? x : x % y;
            default: e = '0;
        endcase
        return e;
    endfunction

    function automatic int latency(input logic [3:0] o);
        return (o >= 4'd10 && o <= 4'd13) ? 33 : 1;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Transaction-level model: an op occupies the block from accept until delivery
    int   cyc        = 0;
    bit   m_busy     = 1'b0;
    int   m_ready_at = 0;
    exp_t m_exp      = '0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_busy <= 1'b0;
        end else if (flush) begin
            m_busy <= 1'b0;
        end else if (!m_busy && in_valid) begin
            m_exp      <= model(op, a, b);
            m_ready_at <= cyc + latency(op);
            m_busy     <= 1'b1;
        end else if (m_busy && cyc >= m_ready_at && out_ready) begin
            m_busy <= 1'b0;
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            chk("in_ready", 64'(in_ready), 64'(!m_busy));
            chk("out_valid", 64'(out_valid), 64'(m_busy && cyc >= m_ready_at));
            if (m_busy && cyc >= m_ready_at) begin
                chk("result", 64'(result), 64'(m_exp.res));
                chk("overflow", 64'(overflow), 64'(m_exp.ovf));
            end
        end
    end

    task automatic issue(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y);
        op       = o;
        a        = x;
        b        = y;
        in_valid = 1'b1;
        @(posedge clk);
        #2;
        in_valid = 1'b0;
        a        = $urandom;
        b        = $urandom;
    endtask

    task automatic wait_valid(output int lat);
        lat = 1;
        while (!out_valid && lat < 40) begin
            @(posedge clk);
            #2;
            lat++;
        end
    endtask

    task automatic release_result();
        out_ready = 1'b1;
        @(posedge clk);
        #2;
        out_ready = 1'b0;
    endtask

    task automatic run_vec(input vec_t v, input string name);
        int lat;
        chk({"model_", name}, 64'(model(v.op, v.a, v.b)), 64'({v.r, v.v}));
        issue(v.op, v.a, v.b);
        wait_valid(lat);
        chk({"latency_", name}, 64'(lat), 64'(latency(v.op)));
        chk({"res_", name}, 64'(result), 64'(v.r));
        chk({"ovf_", name}, 64'(overflow), 64'(v.v));
        release_result();
        chk({"idle_", name}, 64'({in_ready, out_valid}), 64'(2'b10));
    endtask

    initial begin
        int lat;
        rst       = 1'b1;
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        op        = '0;
        a         = '0;
        b         = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_out_valid", 64'(out_valid), 64'(0));
        chk("reset_in_ready", 64'(in_ready), 64'(1));
        chk("reset_result", 64'(result), 64'(0));
        chk("reset_overflow", 64'(overflow), 64'(0));
        #1;
        rst = 1'b0;

        foreach (vecs[i]) run_vec(vecs[i], $sformatf("v%0d", i));

        // Result must hold while the consumer stalls
        issue(4'd4, 32'hFFFF0000, 32'h0F0F0F0F);
        wait_valid(lat);
        for (int k = 0; k < 5; k++) begin
            @(posedge clk);
            #2;
            chk("stall_result", 64'(result), 64'h00000000F0F00F0F);
            chk("stall_busy", 64'({in_ready, out_valid}), 64'(2'b01));
        end
        release_result();

        // Flush together with out_ready drops the result
        issue(4'd0, 32'd1, 32'd1);
        wait_valid(lat);
        flush     = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        #2;
        flush     = 1'b0;
        out_ready = 1'b0;
        chk("flush_done", 64'({in_ready, out_valid}), 64'(2'b10));

        // Flush mid-divide: no result pulse, old result untouched
        issue(4'd12, 32'd100, 32'd7);
        repeat (5) @(posedge clk);
        #2;
        flush = 1'b1;
        @(posedge clk);
        #2;
        flush = 1'b0;
        chk("flush_busy", 64'({in_ready, out_valid}), 64'(2'b10));
        repeat (40) @(posedge clk);
        #2;
        chk("flush_busy_result", 64'(result), 64'(2));

        // Flush beats in_valid
        op       = 4'd0;
        a        = 32'd9;
        b        = 32'd9;
        in_valid = 1'b1;
        flush    = 1'b1;
        @(posedge clk);
        #2;
        in_valid = 1'b0;
        flush    = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        chk("flush_vs_accept", 64'({in_ready, out_valid}), 64'(2'b10));

        // Mixed ops checked by the model only
        for (int k = 0; k < 12; k++) begin
            issue(4'($urandom_range(0, 15)), $urandom, $urandom);
            wait_valid(lat);
            release_result();
        end

        // Reset in the middle of a multiply
        issue(4'd0, 32'd5, 32'd3);
        wait_valid(lat);
        release_result();
        issue(4'd10, 32'h00003039, 32'h000003E8);
        repeat (7) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("midbusy_rst_out_valid", 64'(out_valid), 64'(0));
        chk("midbusy_rst_in_ready", 64'(in_ready), 64'(1));
        chk("midbusy_rst_result", 64'(result), 64'(0));
        @(posedge clk);
        #2;
        rst = 1'b0;

        // Multiply still correct after reset
        issue(4'd10, 32'h00003039, 32'h000003E8);
        wait_valid(lat);
        chk("mul_after_rst", 64'(result), 64'h0000000000BC5EA8);
        chk("mul_after_rst_lat", 64'(lat), 64'(33));
        release_result();

        repeat (2) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

endmodule
